dmem_port_arbiter: RTL and testbench

//  Arbitrates the single-port data RAM behind the M1 stage between the pipeline
//  (read/write per instruction) and the RAM loader stream used while mem_ram_load
//  is active. Sequences the loader burst with an auto-incrementing address.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_load_seq.sv | 82 ++++++++
 rtl/dmem_port_arbiter.sv | 96 +++++++++
 tb/tb_dmem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-RAM port arbiter
package dmem_arb_pkg;

  localparam int ADDR_W_DEF       = 7;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } load_state_e;

endpackage

// File: rtl/dmem_load_seq.sv
// rtl/dmem_load_seq.sv - loader burst sequencer: mode FSM, write address, word count, done pulse
module dmem_load_seq
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              l_load,
  input  logic              l_grant,
  output logic              load_active,
  output logic [ADDR_W-1:0] l_addr,
  output logic [ADDR_W:0]   l_count,
  output logic              l_done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (l_load) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (l_grant) begin
          count_d = count_q + (ADDR_W + 1)'(1);
          // The address parks on the last word instead of wrapping.
          if (addr_q == ADDR_LAST) begin
            if (l_load) begin
              state_d = ST_FULL;
              done_d  = 1'b1;
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        if (!l_load) begin
          state_d = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (!l_load) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign load_active = (state_q == ST_LOAD);
  assign l_addr      = addr_q;
  assign l_count     = count_q;
  assign l_done      = done_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - single-port data RAM arbiter: pipeline priority, loader starvation guard
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [31:0]       p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              l_load,
  input  logic              l_valid,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ready,
  output logic              l_done,
  output logic [ADDR_W:0]   l_count,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic              load_active;
  logic [ADDR_W-1:0] l_addr;
  logic              lreq, force_l, p_grant, l_grant, p_req_live;
  logic [SW-1:0]     starve_q, starve_d;
  logic              p_rvalid_q, p_rvalid_d;
  logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
  logic              addr_unused;

  assign addr_unused = ^{p_addr[31:ADDR_W+2], p_addr[1:0]};

  dmem_load_seq #(.ADDR_W(ADDR_W)) u_load_seq (
    .clock       (clock),
    .reset       (reset),
    .l_load      (l_load),
    .l_grant     (l_grant),
    .load_active (load_active),
    .l_addr      (l_addr),
    .l_count     (l_count),
    .l_done      (l_done)
  );

  always_comb begin
    // Gating with reset keeps every RAM strobe quiet while reset is held.
    p_req_live = reset & p_req;
    lreq       = load_active & l_valid;
    force_l    = lreq & (starve_q == STARVE_MAX);
    p_grant    = p_req_live & ~force_l;
    l_grant    = force_l | (lreq & ~p_req_live);

    starve_d = starve_q;
    if (l_grant || !lreq) begin
      starve_d = '0;
    end else if (p_grant && starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end

    p_rvalid_d = p_grant & ~p_we;
    p_rdata_d  = p_rvalid_q ? ram_rdata : p_rdata_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q   <= '0;
      p_rvalid_q <= 1'b0;
      p_rdata_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      p_rvalid_q <= p_rvalid_d;
      p_rdata_q  <= p_rdata_d;
    end
  end

  assign p_stall   = p_req_live & force_l;
  assign l_ready   = l_grant;
  assign ram_en    = p_grant | l_grant;
  assign ram_we    = l_grant | (p_grant & p_we);
  assign ram_addr  = l_grant ? l_addr : (p_grant ? p_addr[ADDR_W+1:2] : '0);
  assign ram_wdata = l_grant ? l_wdata : (p_grant ? p_wdata : '0);
  // Read data is presented straight from the RAM in the return cycle, then held.
  assign p_rvalid  = p_rvalid_q;
  assign p_rdata   = p_rvalid_q ? ram_rdata : p_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter with a behavioural RAM
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        p_req, p_we;
  logic [31:0] p_addr, p_wdata;
  logic        p_stall, p_rvalid;
  logic [31:0] p_rdata;
  logic        l_load, l_valid;
  logic [31:0] l_wdata;
  logic        l_ready, l_done;
  logic [7:0]  l_count;
  logic        ram_en, ram_we;
  logic [6:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:127];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          rv_seen = 0;

  dmem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .p_req     (p_req),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_stall   (p_stall),
    .p_rvalid  (p_rvalid),
    .p_rdata   (p_rdata),
    .l_load    (l_load),
    .l_valid   (l_valid),
    .l_wdata   (l_wdata),
    .l_ready   (l_ready),
    .l_done    (l_done),
    .l_count   (l_count),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (p_rvalid) begin
      rv_seen++;
      if (exp_q.size() == 0) chk("rvalid_spurious", 1, 0);
      else                   chk("rdata", p_rdata, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd);
    p_req = 1'b1; p_we = we; p_addr = addr; p_wdata = wd;
    @(negedge clock);
    chk("pipe_stall", p_stall, 0);
    chk("pipe_ram_we", ram_we, we);
    if (!we) exp_q.push_back(exp_rd);
    step();
    p_req = 1'b0; p_we = 1'b0;
    if (!we) begin
      @(negedge clock);
      chk("rvalid_latency", p_rvalid, 1);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int idx, dones, cyc, rv_base;
    reset = 1'b0; p_req = 1'b1; p_we = 1'b0; p_addr = 32'h10; p_wdata = '0;
    l_load = 1'b0; l_valid = 1'b0; l_wdata = '0;

    // Reset state, with a pipeline read requested throughout
    repeat (2) @(negedge clock);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_p_rvalid", p_rvalid, 0);
    chk("rst_p_rdata", p_rdata, 0);
    chk("rst_l_count", l_count, 0);
    chk("rst_l_ready", l_ready, 0);
    chk("rst_l_done", l_done, 0);
    chk("rst_p_stall", p_stall, 0);

    // Reset asserted mid-read discards the in-flight read
    step();
    reset = 1'b1;
    @(negedge clock);
    chk("midread_ram_en", ram_en, 1);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("midread_p_rvalid", p_rvalid, 0);
    chk("midread_ram_en_rst", ram_en, 0);
    p_req = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Pipeline writes, reads, ignored address bits, read-data hold
    pipe(1'b1, 32'h8,   32'h1234,     '0);
    pipe(1'b1, 32'h10,  32'hDEADBEEF, '0);
    pipe(1'b0, 32'h10,  '0,           32'hDEADBEEF);
    pipe(1'b0, 32'h8,   '0,           32'h1234);
    pipe(1'b0, 32'h213, '0,           32'hDEADBEEF);
    @(negedge clock);
    chk("rdata_hold_rvalid", p_rvalid, 0);
    chk("rdata_hold", p_rdata, 32'hDEADBEEF);
    step();

    // Full 128-word burst
    l_load = 1'b1; l_valid = 1'b1; idx = 0; dones = 0; cyc = 0;
    l_wdata = 32'hA000_0000;
    while (idx < 128 && cyc < 400) begin
      @(negedge clock);
      if (l_done) dones++;
      if (l_ready) begin
        chk("load_addr", ram_addr, idx);
        chk("load_wdata", ram_wdata, 32'hA000_0000 + idx);
        idx++;
      end
      cyc++;
      step();
      l_wdata = 32'hA000_0000 + idx;
    end
    chk("load_words", idx, 128);
    chk("load_early_done", dones, 0);
    @(negedge clock);
    chk("load_done_pulse", l_done, 1);
    chk("load_count", l_count, 128);
    chk("full_ready", l_ready, 0);
    step();
    @(negedge clock);
    chk("load_done_single", l_done, 0);
    chk("full_ready_hold", l_ready, 0);
    step();
    pipe(1'b0, 32'h14,  '0, 32'hA000_0005);
    pipe(1'b0, 32'h1FC, '0, 32'hA000_007F);
    l_load = 1'b0; l_valid = 1'b0;
    step();

    // Starvation guard: loader forced in every 9th cycle of LOAD
    rv_base = rv_seen;
    l_load = 1'b1; l_valid = 1'b1; l_wdata = 32'hB000_0000;
    p_req = 1'b1; p_we = 1'b0; p_addr = 32'h1FC;
    @(negedge clock);
    chk("starve_idle_stall", p_stall, 0);
    exp_q.push_back(32'hA000_007F);
    step();
    for (int k = 0; k < 36; k++) begin
      @(negedge clock);
      if (k % 9 == 8) begin
        chk("starve_force_ready", l_ready, 1);
        chk("starve_force_stall", p_stall, 1);
        chk("starve_force_addr", ram_addr, k / 9);
      end else begin
        chk("starve_p_ready", l_ready, 0);
        chk("starve_p_stall", p_stall, 0);
        exp_q.push_back(32'hA000_007F);
      end
      step();
      if (k % 9 == 8) l_wdata = 32'hB000_0001 + k / 9;
    end
    p_req = 1'b0; l_load = 1'b0; l_valid = 1'b0;
    @(negedge clock);
    chk("starve_count", l_count, 4);
    step();
    repeat (2) step();
    chk("starve_no_lost_reads", rv_seen - rv_base, 33);

    // Abandoned burst after 5 words, then restart from address 0
    l_load = 1'b1; l_valid = 1'b1; idx = 0; dones = 0; cyc = 0;
    l_wdata = 32'hC000_0000;
    while (idx < 5 && cyc < 50) begin
      @(negedge clock);
      if (l_done) dones++;
      if (l_ready) idx++;
      cyc++;
      step();
      l_wdata = 32'hC000_0000 + idx;
    end
    l_load = 1'b0; l_valid = 1'b0;
    @(negedge clock);
    chk("abandon_count", l_count, 5);
    chk("abandon_ready", l_ready, 0);
    if (l_done) dones++;
    step();
    @(negedge clock);
    if (l_done) dones++;
    l_load = 1'b1; l_valid = 1'b1; l_wdata = 32'hD000_0000;
    step();
    @(negedge clock);
    chk("restart_count", l_count, 0);
    chk("restart_ready", l_ready, 1);
    chk("restart_addr", ram_addr, 0);
    if (l_done) dones++;
    step();
    l_load = 1'b0; l_valid = 1'b0;
    @(negedge clock);
    if (l_done) dones++;
    chk("abandon_no_done", dones, 0);
    step();
    pipe(1'b0, 32'h10, '0, 32'hC000_0004);
    pipe(1'b0, 32'h0,  '0, 32'hD000_0000);

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
